// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R) with N_CH per-lane valid/ready bits and a shared R payload.
// N_CH=1 gives a plain single AXI read port.
interface axi_read_arbiter_if #(
    parameter int unsigned N_CH   = 1,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [N_CH-1:0]        ar_valid;
    logic [N_CH-1:0]        ar_ready;
    logic [N_CH*ID_W-1:0]   ar_id;
    logic [N_CH*ADDR_W-1:0] ar_addr;
    logic [N_CH*8-1:0]      ar_len;
    logic [N_CH*3-1:0]      ar_size;
    logic [N_CH*2-1:0]      ar_burst;

    logic [N_CH-1:0]        r_valid;
    logic [N_CH-1:0]        r_ready;
    logic [ID_W-1:0]        r_id;
    logic [DATA_W-1:0]      r_data;
    logic [1:0]             r_resp;
    logic                   r_last;

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one downstream AXI read port among N_REQ requesters.
// Optional per-requester outstanding-burst limit: define AXI_READ_ARB_OUTST_LIMIT_EN.
module axi_read_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               rst,
    axi_read_arbiter_if.slave  s,
    axi_read_arbiter_if.master m,
    output logic               bad_id
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned N_PAD = 1 << IDX_W;

    // Elaboration-time parameter sanity checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("axi_read_arbiter: N_REQ must be within 2..8");
    end
    if (MAX_OUTST < 1 || ID_W < 1 || ADDR_W < 1 || DATA_W < 1) begin : g_bad_width
        $error("axi_read_arbiter: MAX_OUTST and bus widths must be non-zero");
    end

    logic              can_load;
    logic              found;
    logic              accept;
    logic [N_REQ-1:0]  at_limit;
    logic [N_PAD-1:0]  elig;
    logic [PTR_W-1:0]  cand;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_next;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic [2:0]        sel_size;
    logic [1:0]        sel_burst;
    logic [IDX_W-1:0]  r_idx;
    logic              r_hit;

    assign can_load = !m.ar_valid || m.ar_ready;
    assign accept   = can_load && found;
    assign rr_next  = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);

    // Padded to a power of two so any index value is in range
    always_comb begin
        elig             = '0;
        elig[N_REQ-1:0]  = s.ar_valid & ~at_limit;
    end

    // First eligible requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + PTR_W'(k);
            if (cand >= PTR_W'(N_REQ)) begin
                cand = cand - PTR_W'(N_REQ);
            end
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        s.ar_ready = '0;
        sel_id     = '0;
        sel_addr   = '0;
        sel_len    = '0;
        sel_size   = '0;
        sel_burst  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                s.ar_ready[i] = accept;
                sel_id        = s.ar_id[i*ID_W +: ID_W];
                sel_addr      = s.ar_addr[i*ADDR_W +: ADDR_W];
                sel_len       = s.ar_len[i*8 +: 8];
                sel_size      = s.ar_size[i*3 +: 3];
                sel_burst     = s.ar_burst[i*2 +: 2];
            end
        end
    end

    // Forward AR slice; a same-cycle drain and accept simply overwrites the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m.ar_valid <= 1'b0;
            m.ar_id    <= '0;
            m.ar_addr  <= '0;
            m.ar_len   <= '0;
            m.ar_size  <= '0;
            m.ar_burst <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            m.ar_valid <= 1'b1;
            m.ar_id    <= {win, sel_id};
            m.ar_addr  <= sel_addr;
            m.ar_len   <= sel_len;
            m.ar_size  <= sel_size;
            m.ar_burst <= sel_burst;
            rr_ptr     <= rr_next;
        end else if (m.ar_ready) begin
            m.ar_valid <= 1'b0;
        end
    end

    assign r_idx    = m.r_id[IDX_W+ID_W-1 -: IDX_W];
    assign s.r_id   = m.r_id[ID_W-1:0];
    assign s.r_data = m.r_data;
    assign s.r_resp = m.r_resp;
    assign s.r_last = m.r_last;

    // R routing by index prefix; unmapped indices are sunk with ready held high
    always_comb begin
        r_hit     = 1'b0;
        m.r_ready = 1'b1;
        s.r_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_idx == IDX_W'(i)) begin
                r_hit        = 1'b1;
                s.r_valid[i] = m.r_valid;
                m.r_ready    = s.r_ready[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_id <= 1'b0;
        end else if (m.r_valid && !r_hit) begin
            bad_id <= 1'b1;
        end
    end

`ifdef AXI_READ_ARB_OUTST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic [N_REQ-1:0][CNT_W-1:0] outst_cnt;
    logic [N_REQ-1:0]            cnt_inc;
    logic [N_REQ-1:0]            cnt_dec;

    always_comb begin
        at_limit = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            at_limit[i] = (outst_cnt[i] == CNT_W'(MAX_OUTST));
        end
    end

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_inc[i] = s.ar_valid[i] && s.ar_ready[i];
            cnt_dec[i] = s.r_valid[i] && s.r_ready[i] && m.r_last;
        end
    end

    // Decrement saturates at zero so a stray last beat cannot wrap the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    outst_cnt[i] <= outst_cnt[i] + CNT_W'(1);
                end else if (!cnt_inc[i] && cnt_dec[i] && outst_cnt[i] != '0) begin
                    outst_cnt[i] <= outst_cnt[i] - CNT_W'(1);
                end
            end
        end
    end
`else
    assign at_limit = '0;
`endif

endmodule
